cpu_core: RTL and testbench
===========================

# cpu_core

Multi-cycle, non-pipelined 32-bit load/store processor. It fetches 32-bit instructions from a separate instruction memory and executes a small register-register/immediate ISA over sixteen 32-bit registers. It accesses a separate data memory for loads and stores. It reports run/halt/error status on `error_indicator`. It is the top-level compute core; memories and the status monitor sit outside it.

## Interface
Parameters: none.
- `clk` in 1: single core clock, rising-edge.
- `reset` in 1: synchronous, active-high reset.
- `clk_en` in 1: when low, all state (PC, registers, FSM, outputs) holds.
- `instruction_memory_a` out 32: byte address of the fetch; equals PC.
- `instruction_memory_en` out 1: fetch strobe; high only in FETCH.
- `instruction_memory_v` in 32: fetched word, little-endian.
- `data_memory_a` out 32: byte address of the load/store.
- `data_memory_read` out 1: load strobe; high only in MEM for LDR.
- `data_memory_write` out 1: store strobe; high only in MEM for STR.
- `data_memory_in_v` in 32: load data.
- `data_memory_out_v` out 32: store data.
- `error_indicator` out 2: 2'b10 = running, 2'b00 = HALT, 2'b01 = ERROR. 2'b11 is never driven.

## Operation
- Instruction format:
  - opcode [31:24], Rd [23:20], Rn [19:16], Rm [3:0], imm16 [15:0].
  - Bits not used by an opcode are ignored.
- Register-register opcodes:
  - 00 ADD Rd=Rn+Rm
  - 01 SUB Rd=Rn-Rm
  - 02 AND
  - 03 OR
  - 04 XOR
  - 05 LSL Rd=Rn<<Rm[4:0]
  - 06 LSR (logical) Rd=Rn>>Rm[4:0]
- Immediate opcodes:
  - 10 ADDI Rd=Rn+sext(imm16)
  - 11 MOVI Rd=zext(imm16)
  - 12 MOVT Rd[31:16]=imm16, with Rd[15:0] kept.
- Memory opcodes:
  - 20 LDR Rd=mem32[Rn+sext(imm16)]
  - 21 STR mem32[Rn+sext(imm16)]=Rd
- Control-flow opcodes:
  - 30 B: PC=PC+4+(sext(imm16)<<2)
  - 31 BEQ: branch if Rd==Rn
  - 32 BNE: branch if Rd!=Rn
  - C8 NOP
  - FF HALT
- Any other opcode raises ERROR.
- All arithmetic is modulo 2^32. No flags. No alignment checks; addresses are passed through unchanged.
- Non-branching instructions advance PC by 4.
- FSM states:
  - FETCH: drive the fetch address and strobe; at the clock edge capture `instruction_memory_v` into IR.
  - EXECUTE: decode and perform ALU, branch or register writeback. For LDR/STR, latch the effective address and store data, then go to MEM. HALT goes to HALTED; an undefined opcode goes to ERROR. Everything else returns to FETCH.
  - MEM: drive the data address and one strobe. LDR writes Rd from `data_memory_in_v` at the end of MEM. Then go to FETCH.
  - HALTED and ERROR are terminal; only reset leaves them. No fetch and no strobes are issued in either state.
- The memories are synchronous. Data for an address and strobe driven during a cycle is valid at that cycle's closing edge.
- `data_memory_read` and `data_memory_write` are never high together. Neither is ever high together with `instruction_memory_en`.

## Timing
- Reset values (reset sampled at a rising edge with `clk_en` ignored):
  - PC=0, all registers=0, state=FETCH, IR=0.
  - `error_indicator`=2'b10.
  - All strobes 0; `data_memory_a`=0; `data_memory_out_v`=0.
- Reset asserted mid-instruction aborts that instruction. Any pending store strobe drops in the same cycle.
- Latency:
  - ALU, immediate, branch and NOP instructions: 2 cycles.
  - LDR and STR: 3 cycles.
  - HALT: `error_indicator`=2'b00 from the edge ending its EXECUTE.
  - Undefined opcode: `error_indicator`=2'b01 from the edge ending its EXECUTE.
- `instruction_memory_a` is stable throughout FETCH.
- `data_memory_a` and `data_memory_out_v` are stable throughout MEM.
- Stores last exactly one cycle.
- When Rd is the same register as Rn or Rm, sources are read before the write.

## Test plan
- Reset, then word 0 = FF000000 (HALT): `error_indicator`=2'b10 during reset, fetch address 0, 2'b00 two cycles after release.
- Program 11100005, 11200007, 00312000... must be encoded with Rm in [3:0]:
  - MOVI R1,5 = 11100005; MOVI R2,7 = 11200007.
  - ADD R3,R1,R2 = 00310002; STR R3,[R0,#0x100] = 21300100; HALT.
  - Required: data bytes 0x100..0x103 = 0C 00 00 00, then HALT.
- Data word DEADBEEF at 0x200; LDR R4,[R0,#0x200] = 20400200; STR R4,[R0,#0x204] = 21400204; HALT. Required: 0x204 reads DEADBEEF and `data_memory_read` is high for exactly one cycle.
- MOVI R1,1; BEQ R1,R1,+1 (31110001); MOVI R5,9; MOVI R6,3; STR R5 and R6. Required: R5=0 (skipped), R6=3. Also BNE R1,R1 is not taken.
- Opcode 7F000000 at 0: `error_indicator`=2'b01 after 2 cycles; no further `instruction_memory_en`.
- `clk_en` held low for 5 cycles mid-ADD program: PC, outputs and strobes frozen, and the final result is unchanged versus an uninterrupted run.

Source files
------------

// File: rtl/cpu_core_if.sv
// Memory-side bus of cpu_core: instruction fetch port and data load/store port.
// The core holds the master modport; the memory models hold the slave.
interface cpu_core_if;
    logic [31:0] instruction_memory_a;
    logic        instruction_memory_en;
    logic [31:0] instruction_memory_v;
    logic [31:0] data_memory_a;
    logic        data_memory_read;
    logic        data_memory_write;
    logic [31:0] data_memory_in_v;
    logic [31:0] data_memory_out_v;

    modport master (
        output instruction_memory_a,
        output instruction_memory_en,
        input  instruction_memory_v,
        output data_memory_a,
        output data_memory_read,
        output data_memory_write,
        output data_memory_out_v,
        input  data_memory_in_v
    );

    modport slave (
        input  instruction_memory_a,
        input  instruction_memory_en,
        output instruction_memory_v,
        input  data_memory_a,
        input  data_memory_read,
        input  data_memory_write,
        input  data_memory_out_v,
        output data_memory_in_v
    );
endinterface

// File: rtl/cpu_core.sv
// Multi-cycle load/store core: FETCH -> EXECUTE (-> MEM) over sixteen 32-bit registers.
// state     | meaning
// S_FETCH   | drive PC to instruction memory, capture the word into IR
// S_EXECUTE | decode IR; ALU/branch/writeback, or latch address/data for a memory op
// S_MEM     | drive data address and one strobe; LDR writes Rd at the closing edge
// S_HALTED  | HALT executed; terminal until reset
// S_ERROR   | undefined opcode executed; terminal until reset
module cpu_core (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    cpu_core_if.master       mem,
    output logic [1:0]       error_indicator
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXECUTE,
        S_MEM,
        S_HALTED,
        S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] dma_q, dma_d;
    logic [31:0] dwd_q, dwd_d;
    logic [31:0] rf_q [16];

    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd;

    logic [7:0]  opcode;
    logic [15:0] imm;
    logic [31:0] imm_sext;
    logic [31:0] rd_val, rn_val, rm_val;
    logic [31:0] br_target;
    logic        is_ldr, is_str;

    assign opcode    = ir_q[31:24];
    assign imm       = ir_q[15:0];
    assign imm_sext  = {{16{imm[15]}}, imm};
    assign rd_val    = rf_q[ir_q[23:20]];
    assign rn_val    = rf_q[ir_q[19:16]];
    assign rm_val    = rf_q[ir_q[3:0]];
    assign br_target = pc_q + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
    assign is_ldr    = (opcode == 8'h20);
    assign is_str    = (opcode == 8'h21);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        dma_d   = dma_q;
        dwd_d   = dwd_q;
        rf_we   = 1'b0;
        rf_wa   = ir_q[23:20];
        rf_wd   = '0;
        case (state_q)
            S_FETCH: begin
                ir_d    = mem.instruction_memory_v;
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = S_FETCH;
                pc_d    = pc_q + 32'd4;
                case (opcode)
                    8'h00: begin rf_we = 1'b1; rf_wd = rn_val + rm_val;           end
                    8'h01: begin rf_we = 1'b1; rf_wd = rn_val - rm_val;           end
                    8'h02: begin rf_we = 1'b1; rf_wd = rn_val & rm_val;           end
                    8'h03: begin rf_we = 1'b1; rf_wd = rn_val | rm_val;           end
                    8'h04: begin rf_we = 1'b1; rf_wd = rn_val ^ rm_val;           end
                    8'h05: begin rf_we = 1'b1; rf_wd = rn_val << rm_val[4:0];     end
                    8'h06: begin rf_we = 1'b1; rf_wd = rn_val >> rm_val[4:0];     end
                    8'h10: begin rf_we = 1'b1; rf_wd = rn_val + imm_sext;         end
                    8'h11: begin rf_we = 1'b1; rf_wd = {16'h0000, imm};           end
                    8'h12: begin rf_we = 1'b1; rf_wd = {imm, rd_val[15:0]};       end
                    8'h20: begin
                        dma_d   = rn_val + imm_sext;
                        state_d = S_MEM;
                    end
                    8'h21: begin
                        dma_d   = rn_val + imm_sext;
                        dwd_d   = rd_val;
                        state_d = S_MEM;
                    end
                    8'h30: pc_d = br_target;
                    8'h31: if (rd_val == rn_val) pc_d = br_target;
                    8'h32: if (rd_val != rn_val) pc_d = br_target;
                    8'hC8: ;
                    8'hFF: begin
                        pc_d    = pc_q;
                        state_d = S_HALTED;
                    end
                    default: begin
                        pc_d    = pc_q;
                        state_d = S_ERROR;
                    end
                endcase
            end
            S_MEM: begin
                if (is_ldr) begin
                    rf_we = 1'b1;
                    rf_wd = mem.data_memory_in_v;
                end
                state_d = S_FETCH;
            end
            S_HALTED: state_d = S_HALTED;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_ERROR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            dma_q   <= '0;
            dwd_q   <= '0;
            for (int i = 0; i < 16; i++) rf_q[i] <= '0;
        end else if (clk_en) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            dma_q   <= dma_d;
            dwd_q   <= dwd_d;
            if (rf_we) rf_q[rf_wa] <= rf_wd;
        end
    end

    // Strobes are gated by reset so a pending store is withdrawn before the reset edge.
    assign mem.instruction_memory_a  = pc_q;
    assign mem.instruction_memory_en = !reset && (state_q == S_FETCH);
    assign mem.data_memory_read      = !reset && (state_q == S_MEM) && is_ldr;
    assign mem.data_memory_write     = !reset && (state_q == S_MEM) && is_str;
    assign mem.data_memory_a         = dma_q;
    assign mem.data_memory_out_v     = dwd_q;

    always_comb begin
        case (state_q)
            S_HALTED: error_indicator = 2'b00;
            S_ERROR:  error_indicator = 2'b01;
            default:  error_indicator = 2'b10;
        endcase
    end

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: small programs in a word-addressed memory model,
// results checked against hand-computed values.
module tb_cpu_core;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clk_en = 1'b1;
    logic [1:0] err;

    cpu_core_if bus ();

    cpu_core dut (
        .clk             (clk),
        .reset           (reset),
        .clk_en          (clk_en),
        .mem             (bus.master),
        .error_indicator (err)
    );

    always #5 clk = ~clk;

    logic [31:0] imem [64];
    logic [31:0] dmem [256];

    assign bus.instruction_memory_v = imem[bus.instruction_memory_a[7:2]];
    assign bus.data_memory_in_v     = dmem[bus.data_memory_a[9:2]];

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int rd_cnt  = 0;
    int fe_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: sample the bus as it stands before the edge, then apply the memory write.
    task automatic tick();
        logic        w, r, f, en;
        logic [31:0] a, d;
        w  = bus.data_memory_write;
        r  = bus.data_memory_read;
        f  = bus.instruction_memory_en;
        en = clk_en;
        a  = bus.data_memory_a;
        d  = bus.data_memory_out_v;
        @(posedge clk);
        if (en) begin
            if (w) begin
                dmem[a[9:2]] = d;
                wr_cnt++;
            end
            if (r) rd_cnt++;
            if (f) fe_cnt++;
        end
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++)  imem[i] = 32'hFF000000;
        for (int i = 0; i < 256; i++) dmem[i] = 32'hA5A5A5A5;
    endtask

    task automatic reset_core();
        reset  = 1'b1;
        clk_en = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic run(input int max, output int cyc);
        cyc = 0;
        while (err == 2'b10 && cyc < max) begin
            tick();
            cyc++;
        end
    endtask

    task automatic load_add_prog();
        clear_mem();
        imem[0] = 32'h11100005;
        imem[1] = 32'h11200007;
        imem[2] = 32'h00310002;
        imem[3] = 32'h21300100;
        imem[4] = 32'hFF000000;
    endtask

    logic [31:0] alu_prog [24] = '{
        32'h111000F0, 32'h11200004, 32'h01310002, 32'h02410003,
        32'h03510002, 32'h04610003, 32'h05710002, 32'h06810002,
        32'h1092FFFB, 32'h12901234, 32'h12A08000, 32'h06BA0002,
        32'hC8000000, 32'h00110001, 32'h21300100, 32'h21400104,
        32'h21500108, 32'h2160010C, 32'h21700110, 32'h21800114,
        32'h21900118, 32'h2110011C, 32'h21B00120, 32'hFF000000
    };
    logic [31:0] alu_exp [9] = '{
        32'h000000EC, 32'h000000E0, 32'h000000F4, 32'h0000001C,
        32'h00000F00, 32'h0000000F, 32'h1234FFFF, 32'h000001E0,
        32'h08000000
    };

    initial begin
        int cyc;
        int c0, c1;

        // HALT at word 0, plus reset values
        clear_mem();
        reset  = 1'b1;
        clk_en = 1'b1;
        tick();
        tick();
        chk("rst_err", {30'd0, err}, 32'd2);
        chk("rst_ia", bus.instruction_memory_a, 32'd0);
        chk("rst_ien", {31'd0, bus.instruction_memory_en}, 32'd0);
        chk("rst_dwr", {31'd0, bus.data_memory_write}, 32'd0);
        chk("rst_drd", {31'd0, bus.data_memory_read}, 32'd0);
        chk("rst_da", bus.data_memory_a, 32'd0);
        chk("rst_dout", bus.data_memory_out_v, 32'd0);
        reset = 1'b0;
        #1;
        chk("fetch_en", {31'd0, bus.instruction_memory_en}, 32'd1);
        tick();
        chk("halt_c1", {30'd0, err}, 32'd2);
        tick();
        chk("halt_c2", {30'd0, err}, 32'd0);
        c0 = fe_cnt;
        repeat (4) tick();
        chk("halt_nofetch", fe_cnt - c0, 32'd0);

        // MOVI/MOVI/ADD/STR
        load_add_prog();
        reset_core();
        c0 = wr_cnt;
        run(200, cyc);
        chk("add_cycles", cyc, 32'd11);
        chk("add_result", dmem[64], 32'h0000000C);
        chk("add_stores", wr_cnt - c0, 32'd1);
        chk("add_halt", {30'd0, err}, 32'd0);

        // ALU and immediate coverage
        clear_mem();
        for (int i = 0; i < 24; i++) imem[i] = alu_prog[i];
        reset_core();
        c0 = wr_cnt;
        run(200, cyc);
        chk("alu_cycles", cyc, 32'd57);
        chk("alu_stores", wr_cnt - c0, 32'd9);
        for (int i = 0; i < 9; i++) chk($sformatf("alu_res%0d", i), dmem[64 + i], alu_exp[i]);

        // LDR then STR
        clear_mem();
        dmem[128] = 32'hDEADBEEF;
        imem[0] = 32'h20400200;
        imem[1] = 32'h21400204;
        reset_core();
        c0 = rd_cnt;
        c1 = wr_cnt;
        run(200, cyc);
        chk("ldr_cycles", cyc, 32'd8);
        chk("ldr_copy", dmem[129], 32'hDEADBEEF);
        chk("ldr_reads", rd_cnt - c0, 32'd1);
        chk("ldr_writes", wr_cnt - c1, 32'd1);

        // BEQ taken, BNE not taken
        clear_mem();
        imem[0] = 32'h11100001;
        imem[1] = 32'h31110001;
        imem[2] = 32'h11500009;
        imem[3] = 32'h11600003;
        imem[4] = 32'h21500300;
        imem[5] = 32'h21600304;
        imem[6] = 32'h32110001;
        imem[7] = 32'h11700077;
        imem[8] = 32'h21700308;
        reset_core();
        run(200, cyc);
        chk("br_cycles", cyc, 32'd21);
        chk("beq_skip_r5", dmem[192], 32'h00000000);
        chk("beq_r6", dmem[193], 32'h00000003);
        chk("bne_fall_r7", dmem[194], 32'h00000077);

        // Undefined opcode
        clear_mem();
        imem[0] = 32'h7F000000;
        reset_core();
        tick();
        chk("err_c1", {30'd0, err}, 32'd2);
        tick();
        chk("err_c2", {30'd0, err}, 32'd1);
        c0 = fe_cnt;
        c1 = rd_cnt + wr_cnt;
        repeat (4) tick();
        chk("err_nofetch", fe_cnt - c0, 32'd0);
        chk("err_nomem", rd_cnt + wr_cnt - c1, 32'd0);

        // clk_en low for 5 cycles while ADD is being fetched
        load_add_prog();
        reset_core();
        repeat (4) tick();
        chk("frz_pre_ia", bus.instruction_memory_a, 32'd8);
        clk_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("frz_ia%0d", i), bus.instruction_memory_a, 32'd8);
            chk($sformatf("frz_en%0d", i), {31'd0, bus.instruction_memory_en}, 32'd1);
        end
        clk_en = 1'b1;
        run(200, cyc);
        chk("frz_cycles", cyc, 32'd7);
        chk("frz_result", dmem[64], 32'h0000000C);

        // Reset during MEM of a store withdraws the strobe at once
        load_add_prog();
        reset_core();
        repeat (8) tick();
        chk("mid_wr", {31'd0, bus.data_memory_write}, 32'd1);
        chk("mid_da", bus.data_memory_a, 32'h00000100);
        chk("mid_dout", bus.data_memory_out_v, 32'h0000000C);
        reset = 1'b1;
        #1;
        chk("mid_wr_drop", {31'd0, bus.data_memory_write}, 32'd0);
        tick();
        chk("mid_da_rst", bus.data_memory_a, 32'd0);
        chk("mid_nostore", dmem[64], 32'hA5A5A5A5);
        chk("mid_pc_rst", bus.instruction_memory_a, 32'd0);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
